counter_monitor: RTL and testbench
==================================

Name: counter_monitor

Overview:
- Passive checker sitting on the observation side of the up/down counter block. It samples the counter's control inputs and count output every clock.
- It predicts each next count value and flags any deviation.
- It gives synthesisable self-checking in place of ad-hoc testbench comparisons, and is reusable on hardware as a health monitor.

Parameters:
- WIDTH, 8: width of the observed count.
- ERR_W, 8: width of the saturating error counter.
- MAX_ERR, 4: number of errors that forces the FAULT state; 0 disables FAULT entry.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  asynchronous, active-low reset of the monitor.
- mon_en  input  1  monitor enable; low forces IDLE.
- clear  input  1  synchronous clear of error state and counters; leaves FAULT.
- obs_rst  input  1  observed counter's synchronous active-high reset.
- obs_enable  input  1  observed counter enable.
- obs_dir  input  1  observed counter direction; 1 = up, 0 = down.
- obs_count  input  WIDTH  observed counter output.
- err_pulse  output  1  one-cycle error strobe.
- err_sticky  output  1  latched error flag.
- err_count  output  ERR_W  saturating mismatch count.
- wrap_pulse  output  1  one-cycle strobe on a correct wrap.
- state  output  2  current state: 0 IDLE, 1 SYNC, 2 TRACK, 3 FAULT.

Behaviour:
- Reset (rst = 0, asynchronous):
  - state = IDLE.
  - All outputs 0.
  - Prediction registers exp = 0 and exp_valid = 0.
- Prediction from the inputs sampled at edge k, applied to obs_count at edge k+1:
  - If obs_rst: exp = 0.
  - Else if obs_enable and obs_dir: exp = obs_count + 1, modulo 2^WIDTH.
  - Else if obs_enable: exp = obs_count - 1, modulo 2^WIDTH.
  - Else: exp = obs_count (hold).
- Mismatch: at an edge in TRACK, obs_count != exp.
  - err_pulse = 1 for exactly the following cycle.
  - err_sticky is set.
  - err_count increments and saturates at 2^ERR_W - 1.
  - Latency is one cycle from the offending sample to err_pulse.
- Correct wrap: in TRACK, obs_count == exp, and the previous sample was either:
  - all-ones with up-count enabled, or
  - zero with down-count enabled.
  - Response: wrap_pulse = 1 for one cycle.
  - A wrap produced by obs_rst is not a wrap.
- States:
  - IDLE: no compares, outputs hold their values. mon_en = 1 -> SYNC.
  - SYNC: one edge. Captures the prediction and does no compare. -> TRACK.
  - TRACK: compare every edge, prediction updated every edge. If err_count reaches MAX_ERR (when MAX_ERR > 0) -> FAULT on the same edge the error is recorded.
  - FAULT: compares stop. err_sticky = 1 and err_count are held. err_pulse = 0. Only clear or rst leaves FAULT.
  - mon_en = 0 in any state except FAULT -> IDLE next edge; error state is retained. Re-enabling passes through SYNC, so no false error comes from a stale prediction.
- clear (synchronous, highest priority after rst):
  - err_sticky, err_count, err_pulse and wrap_pulse go to 0.
  - State goes to SYNC if mon_en, else IDLE.
  - clear in the same cycle as a mismatch: clear wins, and the mismatch is not counted.
- Simultaneous obs_rst and obs_enable: obs_rst dominates, so exp = 0.
- rst asserted mid-TRACK: immediate return to IDLE with all outputs 0, independent of clk.
- Arithmetic is unsigned WIDTH-bit with natural wrap. err_count never wraps.

Test Plan:
- Basic up-count, WIDTH=8: mon_en=1, obs_enable=1, obs_dir=1, correct counter 0..20 -> state goes IDLE, SYNC, TRACK; err_sticky stays 0 and err_count stays 0.
- Up-wrap: counter runs 254, 255, 0 with obs_dir=1 -> wrap_pulse=1 exactly one cycle after 0 is sampled; no error. Repeat going down 1, 0, 255 -> one wrap_pulse.
- Fault injection:
  - Count stream 10, 11, 13 -> err_pulse for one cycle after 13 is sampled; err_count=1; err_sticky=1.
  - Next sample 14 is accepted with no second error, because the prediction resyncs to the observed value.
- Hold and reset: obs_enable=0 with count held at 37 -> no error. obs_rst=1 with obs_enable=1, next sample 0 -> no error and no wrap_pulse.
- FAULT entry, MAX_ERR=4:
  - Four mismatches -> state=3 with err_count=4; further mismatches leave err_count at 4.
  - clear with mon_en=1 -> err_count=0, err_sticky=0, state=SYNC, then TRACK.
- Async reset: drive rst=0 mid-TRACK between clock edges -> state=0 and all outputs 0 immediately. After rst=1, mon_en=1 goes through SYNC before any compare.

Source files
------------

// File: rtl/counter_monitor.sv
// Passive health monitor for an up/down counter: predicts every next count,
// flags deviations, counts them (saturating) and latches a FAULT state.
module counter_monitor #(
  parameter int WIDTH   = 8,
  parameter int ERR_W   = 8,
  parameter int MAX_ERR = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mon_en,
  input  logic             clear,
  input  logic             obs_rst,
  input  logic             obs_enable,
  input  logic             obs_dir,
  input  logic [WIDTH-1:0] obs_count,
  output logic             err_pulse,
  output logic             err_sticky,
  output logic [ERR_W-1:0] err_count,
  output logic             wrap_pulse,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SYNC  = 2'd1,
    S_TRACK = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONES  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] CNT_ONE   = WIDTH'(1'b1);
  localparam logic [ERR_W-1:0] ERR_SAT   = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1'b1);
  localparam logic [ERR_W-1:0] FAULT_LVL = ERR_W'(MAX_ERR);
  localparam logic             FAULT_ON  = (MAX_ERR > 0);

  state_t           state_r;
  logic [WIDTH-1:0] exp_r;
  logic             exp_valid_r;
  logic             wrap_cand_r;
  logic             err_pulse_r;
  logic             err_sticky_r;
  logic [ERR_W-1:0] err_count_r;
  logic             wrap_pulse_r;

  logic [WIDTH-1:0] pred_s;
  logic             wrap_cand_s;
  logic             mismatch_s;
  logic [ERR_W-1:0] err_inc_s;
  logic             hits_fault_s;

  // Next-count prediction; a wrap candidate is a boundary value counted across it.
  always_comb begin
    pred_s      = obs_count;
    wrap_cand_s = 1'b0;
    if (obs_rst) begin
      pred_s      = CNT_ZERO;
      wrap_cand_s = 1'b0;
    end else if (obs_enable && obs_dir) begin
      pred_s      = obs_count + CNT_ONE;
      wrap_cand_s = (obs_count == CNT_ONES);
    end else if (obs_enable) begin
      pred_s      = obs_count - CNT_ONE;
      wrap_cand_s = (obs_count == CNT_ZERO);
    end else begin
      pred_s      = obs_count;
      wrap_cand_s = 1'b0;
    end
  end

  // Compare result, saturating increment and fault threshold.
  always_comb begin
    mismatch_s = exp_valid_r && (obs_count != exp_r);
    if (err_count_r == ERR_SAT) begin
      err_inc_s = err_count_r;
    end else begin
      err_inc_s = err_count_r + ERR_ONE;
    end
    hits_fault_s = FAULT_ON && (err_inc_s >= FAULT_LVL);
  end

  // Monitor state machine with registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= S_IDLE;
      exp_r        <= CNT_ZERO;
      exp_valid_r  <= 1'b0;
      wrap_cand_r  <= 1'b0;
      err_pulse_r  <= 1'b0;
      err_sticky_r <= 1'b0;
      err_count_r  <= {ERR_W{1'b0}};
      wrap_pulse_r <= 1'b0;
    end else if (clear) begin
      // Clear beats any same-cycle mismatch; SYNC re-captures the prediction.
      state_r      <= mon_en ? S_SYNC : S_IDLE;
      exp_valid_r  <= 1'b0;
      err_pulse_r  <= 1'b0;
      err_sticky_r <= 1'b0;
      err_count_r  <= {ERR_W{1'b0}};
      wrap_pulse_r <= 1'b0;
    end else if (state_r == S_FAULT) begin
      err_pulse_r  <= 1'b0;
      wrap_pulse_r <= 1'b0;
    end else if (!mon_en) begin
      state_r      <= S_IDLE;
      exp_valid_r  <= 1'b0;
      err_pulse_r  <= 1'b0;
      wrap_pulse_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          state_r      <= S_SYNC;
          err_pulse_r  <= 1'b0;
          wrap_pulse_r <= 1'b0;
        end
        S_SYNC: begin
          state_r      <= S_TRACK;
          exp_r        <= pred_s;
          exp_valid_r  <= 1'b1;
          wrap_cand_r  <= wrap_cand_s;
          err_pulse_r  <= 1'b0;
          wrap_pulse_r <= 1'b0;
        end
        S_TRACK: begin
          exp_r       <= pred_s;
          wrap_cand_r <= wrap_cand_s;
          if (mismatch_s) begin
            err_pulse_r  <= 1'b1;
            err_sticky_r <= 1'b1;
            err_count_r  <= err_inc_s;
            wrap_pulse_r <= 1'b0;
            state_r      <= hits_fault_s ? S_FAULT : S_TRACK;
          end else begin
            err_pulse_r  <= 1'b0;
            wrap_pulse_r <= wrap_cand_r;
            state_r      <= S_TRACK;
          end
        end
        default: begin
          state_r      <= S_IDLE;
          err_pulse_r  <= 1'b0;
          wrap_pulse_r <= 1'b0;
        end
      endcase
    end
  end

  assign err_pulse  = err_pulse_r;
  assign err_sticky = err_sticky_r;
  assign err_count  = err_count_r;
  assign wrap_pulse = wrap_pulse_r;
  assign state      = state_r;

endmodule

// File: tb/tb_counter_monitor.sv
// Scoreboard bench for counter_monitor: stimulus queues the expected
// post-edge outputs, a negedge monitor pops and compares them.
module tb_counter_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mon_en = 1'b0;
  logic       clear = 1'b0;
  logic       obs_rst = 1'b0;
  logic       obs_enable = 1'b0;
  logic       obs_dir = 1'b0;
  logic [7:0] obs_count = 8'd0;
  logic       err_pulse;
  logic       err_sticky;
  logic [7:0] err_count;
  logic       wrap_pulse;
  logic [1:0] state;

  typedef struct {
    int          id;
    logic [12:0] v;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;
  int   step_id = 0;

  counter_monitor #(.WIDTH(8), .ERR_W(8), .MAX_ERR(4)) dut (
    .clk(clk), .rst(rst), .mon_en(mon_en), .clear(clear),
    .obs_rst(obs_rst), .obs_enable(obs_enable), .obs_dir(obs_dir),
    .obs_count(obs_count), .err_pulse(err_pulse), .err_sticky(err_sticky),
    .err_count(err_count), .wrap_pulse(wrap_pulse), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input int id, input logic [12:0] want);
    logic [12:0] got;
    got = {state, err_pulse, err_sticky, err_count, wrap_pulse};
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL step%0d got st=%0d ep=%0b es=%0b ec=%0d wp=%0b want st=%0d ep=%0b es=%0b ec=%0d wp=%0b",
               id, got[12:11], got[10], got[9], got[8:1], got[0],
               want[12:11], want[10], want[9], want[8:1], want[0]);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.id, e.v);
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the edge.
  task automatic c(input logic en, input logic clr, input logic orst,
                   input logic oen, input logic odir, input logic [7:0] cnt,
                   input logic [1:0] st, input logic ep, input logic es,
                   input logic [7:0] ec, input logic wp);
    mon_en     = en;
    clear      = clr;
    obs_rst    = orst;
    obs_enable = oen;
    obs_dir    = odir;
    obs_count  = cnt;
    @(posedge clk);
    #1;
    step_id++;
    sbq.push_back('{step_id, {st, ep, es, ec, wp}});
  endtask

  initial begin
    // reset held
    c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    rst = 1'b1;

    // basic up-count 0..20
    for (int i = 0; i <= 20; i++)
      c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'(i), (i == 0) ? 2'd1 : 2'd2,
        1'b0, 1'b0, 8'd0, 1'b0);

    // up wrap 254,255,0 then down wrap 1,0,255
    c(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd21,  2'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd253, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd254, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd255, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   2'd2, 1'b0, 1'b0, 8'd0, 1'b1);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1,   2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd0,   2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd255, 2'd2, 1'b0, 1'b0, 8'd0, 1'b1);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd254, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);

    // fault injection 10,11,13 then resync on 14
    c(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,  2'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd9,  2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd10, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd11, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd13, 2'd2, 1'b1, 1'b1, 8'd1, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd14, 2'd2, 1'b0, 1'b1, 8'd1, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd15, 2'd2, 1'b0, 1'b1, 8'd1, 1'b0);

    // hold at 37
    c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd37, 2'd0, 1'b0, 1'b1, 8'd1, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd37, 2'd1, 1'b0, 1'b1, 8'd1, 1'b0);
    for (int i = 0; i < 4; i++)
      c(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd37, 2'd2, 1'b0, 1'b1, 8'd1, 1'b0);

    // obs_rst from 255 with up-enable: 0 is no wrap
    c(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 2'd0, 1'b0, 1'b1, 8'd1, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 2'd1, 1'b0, 1'b1, 8'd1, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255, 2'd2, 1'b0, 1'b1, 8'd1, 1'b0);
    c(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd255, 2'd2, 1'b0, 1'b1, 8'd1, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   2'd2, 1'b0, 1'b1, 8'd1, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd1,   2'd2, 1'b0, 1'b1, 8'd1, 1'b0);

    // clear with a same-cycle mismatch, then four errors into FAULT
    c(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd50, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd50, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd60, 2'd2, 1'b1, 1'b1, 8'd1, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd70, 2'd2, 1'b1, 1'b1, 8'd2, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd80, 2'd2, 1'b1, 1'b1, 8'd3, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd90, 2'd3, 1'b1, 1'b1, 8'd4, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd99, 2'd3, 1'b0, 1'b1, 8'd4, 1'b0);
    c(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'd5,  2'd3, 1'b0, 1'b1, 8'd4, 1'b0);
    c(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'd100, 2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd100, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd101, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd200, 2'd2, 1'b1, 1'b1, 8'd1, 1'b0);

    // async reset between edges
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check(-1, 13'd0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd50, 2'd0, 1'b0, 1'b0, 8'd0, 1'b0);
    rst = 1'b1;
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd7,   2'd1, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd99,  2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd100, 2'd2, 1'b0, 1'b0, 8'd0, 1'b0);
    c(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd105, 2'd2, 1'b1, 1'b1, 8'd1, 1'b0);

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain left=%0d want=0", sbq.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
